// File: rtl/beta_mem_port_arbiter_if.sv
// Request/response bundle between the core's three memory requesters, the
// shared bus slave and beta_mem_port_arbiter.
interface beta_mem_port_arbiter_if #(
  parameter int unsigned DataWidth = 32,
  parameter int unsigned AddrWidth = 32
);
  logic                   instr_req_i;
  logic [AddrWidth-1:0]   instr_addr_i;
  logic                   instr_kill_i;
  logic                   instr_ready_o;
  logic                   instr_valid_o;
  logic [DataWidth-1:0]   instr_rdata_o;

  logic                   rdata_req_i;
  logic [AddrWidth-1:0]   rdata_addr_i;
  logic [DataWidth/8-1:0] rdata_strb_i;
  logic                   rdata_ready_o;
  logic                   rdata_valid_o;
  logic [DataWidth-1:0]   rdata_data_o;

  logic                   wdata_req_i;
  logic [AddrWidth-1:0]   wdata_addr_i;
  logic [DataWidth-1:0]   wdata_data_i;
  logic [DataWidth/8-1:0] wdata_strb_i;
  logic                   wdata_ready_o;
  logic                   wdata_valid_o;

  logic                   mem_req_o;
  logic                   mem_we_o;
  logic [AddrWidth-1:0]   mem_addr_o;
  logic [DataWidth-1:0]   mem_wdata_o;
  logic [DataWidth/8-1:0] mem_be_o;
  logic                   mem_gnt_i;
  logic                   mem_rvalid_i;
  logic [DataWidth-1:0]   mem_rdata_i;

  logic                   arb_busy_o;

  // Arbiter view
  modport master (
    input  instr_req_i, instr_addr_i, instr_kill_i,
    output instr_ready_o, instr_valid_o, instr_rdata_o,
    input  rdata_req_i, rdata_addr_i, rdata_strb_i,
    output rdata_ready_o, rdata_valid_o, rdata_data_o,
    input  wdata_req_i, wdata_addr_i, wdata_data_i, wdata_strb_i,
    output wdata_ready_o, wdata_valid_o,
    output mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_be_o,
    input  mem_gnt_i, mem_rvalid_i, mem_rdata_i,
    output arb_busy_o
  );

  // Requester/bus-slave view
  modport slave (
    output instr_req_i, instr_addr_i, instr_kill_i,
    input  instr_ready_o, instr_valid_o, instr_rdata_o,
    output rdata_req_i, rdata_addr_i, rdata_strb_i,
    input  rdata_ready_o, rdata_valid_o, rdata_data_o,
    output wdata_req_i, wdata_addr_i, wdata_data_i, wdata_strb_i,
    input  wdata_ready_o, wdata_valid_o,
    input  mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_be_o,
    output mem_gnt_i, mem_rvalid_i, mem_rdata_i,
    input  arb_busy_o
  );
endinterface

// File: rtl/beta_mem_port_arbiter.sv
// Single-outstanding arbiter sharing one memory bus between fetch, load and store.
// Define BETA_ARB_RR_EN for round-robin arbitration; default is fixed WR > RD > IF.
module beta_mem_port_arbiter #(
  parameter int unsigned DataWidth = 32,
  parameter int unsigned AddrWidth = 32
) (
  input  logic                    clk_i,
  input  logic                    rstn_i,
  beta_mem_port_arbiter_if.master bus
);
  localparam int unsigned StrbWidth = DataWidth / 8;

  typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_WAIT} state_e;
  typedef enum logic [1:0] {OWN_NONE, OWN_IF, OWN_RD, OWN_WR} owner_e;

  state_e               state_q, state_d;
  owner_e               owner_q, owner_d;
  logic                 kill_q, kill_d;
  logic [AddrWidth-1:0] addr_q, addr_d;
  logic [DataWidth-1:0] wdata_q, wdata_d;
  logic [StrbWidth-1:0] be_q, be_d;

  logic                 any_req;
  logic                 arb_take;
  owner_e               winner;
  logic [AddrWidth-1:0] cap_addr;
  logic [DataWidth-1:0] cap_wdata;
  logic [StrbWidth-1:0] cap_be;

  logic mem_req;
  logic ready_if, ready_rd, ready_wr;
  logic valid_if, valid_rd, valid_wr;

  assign any_req = bus.wdata_req_i | bus.rdata_req_i | bus.instr_req_i;

`ifdef BETA_ARB_RR_EN
  owner_e ptr_q, ptr_d;

  // Search starts at the pointer and wraps WR -> RD -> IF -> WR.
  always_comb begin
    winner = OWN_NONE;
    case (ptr_q)
      OWN_RD: begin
        if (bus.rdata_req_i)      winner = OWN_RD;
        else if (bus.instr_req_i) winner = OWN_IF;
        else if (bus.wdata_req_i) winner = OWN_WR;
      end
      OWN_IF: begin
        if (bus.instr_req_i)      winner = OWN_IF;
        else if (bus.wdata_req_i) winner = OWN_WR;
        else if (bus.rdata_req_i) winner = OWN_RD;
      end
      default: begin
        if (bus.wdata_req_i)      winner = OWN_WR;
        else if (bus.rdata_req_i) winner = OWN_RD;
        else if (bus.instr_req_i) winner = OWN_IF;
      end
    endcase
  end

  always_comb begin
    ptr_d = ptr_q;
    if (arb_take) begin
      case (winner)
        OWN_WR:  ptr_d = OWN_RD;
        OWN_RD:  ptr_d = OWN_IF;
        OWN_IF:  ptr_d = OWN_WR;
        default: ptr_d = ptr_q;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) ptr_q <= OWN_WR;
    else         ptr_q <= ptr_d;
  end
`else
  always_comb begin
    winner = OWN_NONE;
    if (bus.wdata_req_i)      winner = OWN_WR;
    else if (bus.rdata_req_i) winner = OWN_RD;
    else if (bus.instr_req_i) winner = OWN_IF;
  end
`endif

  // Fetches always read a full word; loads carry no write data.
  always_comb begin
    cap_addr  = '0;
    cap_wdata = '0;
    cap_be    = '0;
    case (winner)
      OWN_WR: begin
        cap_addr  = bus.wdata_addr_i;
        cap_wdata = bus.wdata_data_i;
        cap_be    = bus.wdata_strb_i;
      end
      OWN_RD: begin
        cap_addr = bus.rdata_addr_i;
        cap_be   = bus.rdata_strb_i;
      end
      OWN_IF: begin
        cap_addr = bus.instr_addr_i;
        cap_be   = '1;
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    kill_d   = kill_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    be_d     = be_q;
    arb_take = 1'b0;
    mem_req  = 1'b0;
    ready_if = 1'b0;
    ready_rd = 1'b0;
    ready_wr = 1'b0;
    valid_if = 1'b0;
    valid_rd = 1'b0;
    valid_wr = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (any_req) begin
          arb_take = 1'b1;
          state_d  = ST_REQ;
        end
      end
      ST_REQ: begin
        mem_req = 1'b1;
        if (bus.instr_kill_i && owner_q == OWN_IF) kill_d = 1'b1;
        if (bus.mem_gnt_i) begin
          ready_if = (owner_q == OWN_IF);
          ready_rd = (owner_q == OWN_RD);
          ready_wr = (owner_q == OWN_WR);
          state_d  = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (bus.instr_kill_i && owner_q == OWN_IF) kill_d = 1'b1;
        if (bus.mem_rvalid_i) begin
          // A kill arriving with the response still suppresses it.
          valid_if = (owner_q == OWN_IF) && !(kill_q || bus.instr_kill_i);
          valid_rd = (owner_q == OWN_RD);
          valid_wr = (owner_q == OWN_WR);
          kill_d   = 1'b0;
          if (any_req) begin
            arb_take = 1'b1;
            state_d  = ST_REQ;
          end else begin
            owner_d = OWN_NONE;
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (arb_take) begin
      owner_d = winner;
      kill_d  = 1'b0;
      addr_d  = cap_addr;
      wdata_d = cap_wdata;
      be_d    = cap_be;
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q <= ST_IDLE;
      owner_q <= OWN_NONE;
      kill_q  <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      kill_q  <= kill_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
    end
  end

  assign bus.mem_req_o     = mem_req;
  assign bus.mem_we_o      = mem_req && (owner_q == OWN_WR);
  assign bus.mem_addr_o    = mem_req ? addr_q  : '0;
  assign bus.mem_wdata_o   = mem_req ? wdata_q : '0;
  assign bus.mem_be_o      = mem_req ? be_q    : '0;

  assign bus.instr_ready_o = ready_if;
  assign bus.rdata_ready_o = ready_rd;
  assign bus.wdata_ready_o = ready_wr;
  assign bus.instr_valid_o = valid_if;
  assign bus.rdata_valid_o = valid_rd;
  assign bus.wdata_valid_o = valid_wr;
  assign bus.instr_rdata_o = valid_if ? bus.mem_rdata_i : '0;
  assign bus.rdata_data_o  = valid_rd ? bus.mem_rdata_i : '0;

  assign bus.arb_busy_o    = (state_q != ST_IDLE);
endmodule
